sd_data_tx_ser: RTL and testbench

SD_DATA_TX_SER -- requirements
Module: sd_data_tx_ser

---
 rtl/sd_tx_ser_pkg.sv | 23 ++
 rtl/sd_data_tx_ser_if.sv | 25 ++
 rtl/sd_crc16_lane.sv | 37 +++
 rtl/sd_data_tx_ser.sv | 149 ++++++++++++++
 tb/tb_sd_data_tx_ser.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_tx_ser_pkg.sv
// Shared types and constants for the SD 4-bit data-line transmit serializer.
package sd_tx_ser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_CRC,
      ST_STOP
   } tx_state_e;

   localparam logic [15:0] CRC16_POLY       = 16'h1021;
   localparam int          NIBBLES_PER_WORD = 8;
   localparam int          CRC_LEN          = 16;

   // Nibble 0 is the most significant nibble of the word.
   function automatic logic [3:0] nibble_sel(input logic [31:0] word, input logic [2:0] idx);
      logic [31:0] shifted;
      shifted = word << {idx, 2'b00};
      return shifted[31:28];
   endfunction

endpackage

// File: rtl/sd_data_tx_ser_if.sv
// Control, FIFO read port and SD DAT line bundle of the transmit serializer.
interface sd_data_tx_ser_if;

   logic        start;
   logic [6:0]  blk_words;
   logic [31:0] fifo_q;
   logic        fifo_empty;
   logic        fifo_rd;
   logic [3:0]  dat_o;
   logic        dat_oe;
   logic        busy;
   logic        done;
   logic        underrun;

   modport master (
      output start, blk_words, fifo_q, fifo_empty,
      input  fifo_rd, dat_o, dat_oe, busy, done, underrun
   );

   modport slave (
      input  start, blk_words, fifo_q, fifo_empty,
      output fifo_rd, dat_o, dat_oe, busy, done, underrun
   );

endinterface

// File: rtl/sd_crc16_lane.sv
// One-bit serial CRC16 (x^16+x^12+x^5+1, init 0) with clear, update and shift-out.
// Compiled in only when SD_TX_CRC_EN is defined.
`ifdef SD_TX_CRC_EN
module sd_crc16_lane
   import sd_tx_ser_pkg::*;
(
   input  logic rclk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic shift,
   input  logic din,
   output logic dout
);

   logic [CRC_LEN-1:0] crc;
   logic               fb;

   assign fb   = din ^ crc[CRC_LEN-1];
   assign dout = crc[CRC_LEN-1];

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         crc <= '0;
      end else if (clr) begin
         crc <= '0;
      end else if (en) begin
         crc <= {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
      end else if (shift) begin
         crc <= {crc[CRC_LEN-2:0], 1'b0};
      end
   end

endmodule
`endif

// File: rtl/sd_data_tx_ser.sv
// SD 4-bit DAT transmit serializer: start bit, FIFO words as nibbles, per-lane CRC16, stop bit.
// Define SD_TX_CRC_EN to build the CRC generators and CRC phase; otherwise DATA goes straight to STOP.
module sd_data_tx_ser
   import sd_tx_ser_pkg::*;
(
   input  logic           rclk,
   input  logic           rst,
   sd_data_tx_ser_if.slave bus
);

   tx_state_e  state;
   logic [6:0] blk_len;
   logic [6:0] word_cnt;
   logic [2:0] nib_cnt;
   logic       fifo_rd_q;
   logic       dat_oe_q;
   logic       busy_q;
   logic       done_q;
   logic       underrun_q;
   logic [3:0] data_nib;
   logic [3:0] crc_bits;
   logic [3:0] dat_o_c;
   logic       accept;
   logic       starve;
   logic       last_nib;
   logic       last_word;

   assign accept    = (state == ST_IDLE) && bus.start && (bus.blk_words != 7'd0);
   assign starve    = (state == ST_DATA) && (nib_cnt == 3'd0) && bus.fifo_empty;
   assign last_nib  = (nib_cnt == 3'(NIBBLES_PER_WORD - 1));
   assign last_word = (word_cnt == blk_len - 7'd1);
   assign data_nib  = nibble_sel(bus.fifo_q, nib_cnt);

`ifdef SD_TX_CRC_EN
   logic [3:0] crc_cnt;
   logic       crc_en;
   logic       crc_shift;

   // Lanes absorb the nibble on the wire; a starved nibble is never sent.
   assign crc_en    = (state == ST_DATA) && !starve;
   assign crc_shift = (state == ST_CRC);

   for (genvar i = 0; i < 4; i++) begin : g_lane
      sd_crc16_lane u_lane (
         .rclk  (rclk),
         .rst   (rst),
         .clr   (accept),
         .en    (crc_en),
         .shift (crc_shift),
         .din   (data_nib[i]),
         .dout  (crc_bits[i])
      );
   end
`else
   assign crc_bits = 4'h0;
`endif

   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         blk_len    <= '0;
         word_cnt   <= '0;
         nib_cnt    <= '0;
         fifo_rd_q  <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
`ifdef SD_TX_CRC_EN
         crc_cnt    <= '0;
`endif
      end else begin
         done_q    <= 1'b0;
         fifo_rd_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  blk_len    <= bus.blk_words;
                  word_cnt   <= '0;
                  nib_cnt    <= '0;
                  underrun_q <= 1'b0;
                  dat_oe_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= ST_START;
               end
            end
            ST_START: state <= ST_DATA;
            ST_DATA: begin
               if (starve) begin
                  underrun_q <= 1'b1;
                  dat_oe_q   <= 1'b0;
                  busy_q     <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  nib_cnt <= nib_cnt + 3'd1;
                  // Pop strobe is registered one nibble early so it is high on nibble 7.
                  if (nib_cnt == 3'(NIBBLES_PER_WORD - 2)) fifo_rd_q <= 1'b1;
                  if (last_nib) begin
                     word_cnt <= word_cnt + 7'd1;
                     if (last_word) begin
`ifdef SD_TX_CRC_EN
                        crc_cnt <= '0;
                        state   <= ST_CRC;
`else
                        state   <= ST_STOP;
`endif
                     end
                  end
               end
            end
            ST_CRC: begin
`ifdef SD_TX_CRC_EN
               crc_cnt <= crc_cnt + 4'd1;
               if (crc_cnt == 4'(CRC_LEN - 1)) state <= ST_STOP;
`else
               state <= ST_STOP;
`endif
            end
            ST_STOP: begin
               dat_oe_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: the default assignment ahead of the case keeps this block purely
   // combinational; any path that left dat_o_c unassigned would infer a latch.
   always_comb begin
      dat_o_c = 4'hF;
      case (state)
         ST_START: dat_o_c = 4'h0;
         ST_DATA:  dat_o_c = data_nib;
         ST_CRC:   dat_o_c = crc_bits;
         default:  dat_o_c = 4'hF;
      endcase
   end

   assign bus.dat_o    = dat_o_c;
   assign bus.dat_oe   = dat_oe_q;
   assign bus.fifo_rd  = fifo_rd_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_sd_data_tx_ser.sv
// Directed/random bench for sd_data_tx_ser; expected line traffic built from the block rules.
// Adapts its timing model to SD_TX_CRC_EN.
module tb_sd_data_tx_ser;

`ifdef SD_TX_CRC_EN
   localparam int CRC_CYC = 16;
`else
   localparam int CRC_CYC = 0;
`endif

   logic rclk = 1'b0;
   logic rst;
   always #5 rclk = ~rclk;

   sd_data_tx_ser_if bus ();

   sd_data_tx_ser dut (
      .rclk (rclk),
      .rst  (rst),
      .bus  (bus)
   );

   logic [31:0] fifo_mem[$];
   logic [31:0] exp_words[$];
   logic [31:0] popped;
   int          pops;
   int          passed = 0;
   int          total  = 0;

   // Show-ahead FIFO model: pop on a strobed edge, head visible after the edge.
   always @(posedge rclk) begin
      if (bus.fifo_rd === 1'b1) begin
         pops++;
         if (fifo_mem.size() > 0) popped = fifo_mem.pop_front();
      end
      bus.fifo_q     <= (fifo_mem.size() > 0) ? fifo_mem[0] : 32'h0;
      bus.fifo_empty <= (fifo_mem.size() == 0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic load(input logic [31:0] w);
      fifo_mem.push_back(w);
      exp_words.push_back(w);
   endtask

   function automatic logic [3:0] word_nib(input logic [31:0] w, input int n);
      return 4'((w >> (28 - 4 * n)) & 32'hF);
   endfunction

`ifdef SD_TX_CRC_EN
   // Remainder of M(x)*x^16 divided by G(x), by long division over the lane's bit stream.
   function automatic logic [15:0] crc_ref(input logic [31:0] words[$], input int lane);
      bit          m[$];
      logic [16:0] g;
      logic [15:0] r;
      int          len;
      g = 17'h11021;
      foreach (words[w])
         for (int n = 0; n < 8; n++) m.push_back(words[w][28 - 4 * n + lane]);
      len = m.size();
      for (int i = 0; i < 16; i++) m.push_back(1'b0);
      for (int i = 0; i < len; i++)
         if (m[i]) for (int j = 0; j <= 16; j++) m[i + j] = m[i + j] ^ g[16 - j];
      for (int j = 0; j < 16; j++) r[15 - j] = m[len + j];
      return r;
   endfunction
`endif

   // Launch a block of n words already loaded and check every line cycle up to done.
   task automatic run_block(input int n, input string tag, input int poke_k);
      logic [15:0] crc[4];
      logic [3:0]  ed;
      logic        eoe, ebusy, edone, erd;
      int          occ;
      occ = 8 * n + 2 + CRC_CYC;
`ifdef SD_TX_CRC_EN
      for (int l = 0; l < 4; l++) crc[l] = crc_ref(exp_words, l);
`else
      for (int l = 0; l < 4; l++) crc[l] = 16'h0;
`endif
      pops = 0;
      @(negedge rclk);
      bus.start     = 1'b1;
      bus.blk_words = 7'(n);
      for (int k = 1; k <= occ + 1; k++) begin
         @(negedge rclk);
         if (k == 1) bus.start = 1'b0;
         eoe = 1'b1; ebusy = 1'b1; edone = 1'b0; erd = 1'b0; ed = 4'hF;
         if (k == 1) begin
            ed = 4'h0;
         end else if (k <= 8 * n + 1) begin
            ed  = word_nib(exp_words[(k - 2) / 8], (k - 2) % 8);
            erd = ((k - 2) % 8 == 7);
         end else if (k < occ) begin
            for (int l = 0; l < 4; l++) ed[l] = crc[l][15 - (k - 8 * n - 2)];
         end else if (k == occ + 1) begin
            eoe = 1'b0; ebusy = 1'b0; edone = 1'b1;
         end
         chk($sformatf("%s_k%0d_dat_o", tag, k), bus.dat_o, ed);
         chk($sformatf("%s_k%0d_dat_oe", tag, k), bus.dat_oe, eoe);
         chk($sformatf("%s_k%0d_busy", tag, k), bus.busy, ebusy);
         chk($sformatf("%s_k%0d_done", tag, k), bus.done, edone);
         chk($sformatf("%s_k%0d_fifo_rd", tag, k), bus.fifo_rd, erd);
         chk($sformatf("%s_k%0d_underrun", tag, k), bus.underrun, 1'b0);
         if (poke_k > 0 && k == poke_k) begin
            bus.start     = 1'b1;
            bus.blk_words = 7'd1;
         end else if (poke_k > 0 && k == poke_k + 1) begin
            bus.start = 1'b0;
         end
      end
      @(negedge rclk);
      chk({tag, "_done_once"}, bus.done, 1'b0);
      chk({tag, "_idle_busy"}, bus.busy, 1'b0);
      chk({tag, "_pops"}, pops, n);
      exp_words.delete();
   endtask

   initial begin
      int n;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.blk_words = 7'd0;
      repeat (3) @(negedge rclk);
      chk("rst_dat_o", bus.dat_o, 4'hF);
      chk("rst_dat_oe", bus.dat_oe, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_underrun", bus.underrun, 1'b0);
      chk("rst_fifo_rd", bus.fifo_rd, 1'b0);
      rst = 1'b0;
      @(negedge rclk);

      // Zero-length request must be ignored.
      bus.start     = 1'b1;
      bus.blk_words = 7'd0;
      @(negedge rclk);
      bus.start = 1'b0;
      chk("zero_len_busy", bus.busy, 1'b0);
      chk("zero_len_oe", bus.dat_oe, 1'b0);
      @(negedge rclk);
      chk("zero_len_busy2", bus.busy, 1'b0);

      load(32'h0);
      run_block(1, "zero_word", 0);
      load(32'h12345678);
      run_block(1, "count_word", 0);

      for (int i = 0; i < 3; i++) load($urandom);
      run_block(3, "three_words", 12);

      repeat (2) begin
         n = $urandom_range(2, 6);
         for (int i = 0; i < n; i++) load($urandom);
         run_block(n, "rand_len", 0);
      end

      for (int i = 0; i < 127; i++) load($urandom);
      run_block(127, "max_len", 0);

      // Underrun: two words requested, one available.
      load($urandom);
      pops = 0;
      @(negedge rclk);
      bus.start     = 1'b1;
      bus.blk_words = 7'd2;
      for (int k = 1; k <= 16; k++) begin
         @(negedge rclk);
         if (k == 1) bus.start = 1'b0;
         if (k <= 9) begin
            chk($sformatf("urun_k%0d_oe", k), bus.dat_oe, 1'b1);
            if (k >= 2)
               chk($sformatf("urun_k%0d_dat_o", k), bus.dat_o, word_nib(exp_words[0], k - 2));
         end else if (k == 10) begin
            chk("urun_k10_oe", bus.dat_oe, 1'b1);
            chk("urun_k10_busy", bus.busy, 1'b1);
            chk("urun_k10_done", bus.done, 1'b0);
         end else begin
            chk($sformatf("urun_k%0d_oe", k), bus.dat_oe, 1'b0);
            chk($sformatf("urun_k%0d_dat_o", k), bus.dat_o, 4'hF);
            chk($sformatf("urun_k%0d_busy", k), bus.busy, 1'b0);
            chk($sformatf("urun_k%0d_done", k), bus.done, 1'b0);
            chk($sformatf("urun_k%0d_underrun", k), bus.underrun, 1'b1);
         end
      end
      chk("urun_pops", pops, 1);
      exp_words.delete();
      load($urandom);
      run_block(1, "after_underrun", 0);

      // Asynchronous reset in the middle of DATA.
      load($urandom);
      load($urandom);
      @(negedge rclk);
      bus.start     = 1'b1;
      bus.blk_words = 7'd2;
      for (int k = 1; k <= 5; k++) begin
         @(negedge rclk);
         if (k == 1) bus.start = 1'b0;
      end
      chk("mid_rst_pre_dat_o", bus.dat_o, word_nib(exp_words[0], 3));
      chk("mid_rst_pre_busy", bus.busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_oe", bus.dat_oe, 1'b0);
      chk("mid_rst_dat_o", bus.dat_o, 4'hF);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_fifo_rd", bus.fifo_rd, 1'b0);
      @(negedge rclk);
      rst = 1'b0;
      fifo_mem.delete();
      exp_words.delete();
      chk("mid_rst_idle_busy", bus.busy, 1'b0);
      load($urandom);
      run_block(1, "after_reset", 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
